logica_push_vc: RTL and testbench
=================================

# logica_push_vc

Push-side routing logic for the virtual-channel stage of the transmission layer. It drains the main input FIFO and classifies each 6-bit word by a class bit. It then pushes the word into the VC0 or VC1 FIFO, pausing when either VC FIFO nears capacity. The block also keeps per-channel push counters and a sticky overflow flag for verification.

## Interface
- DATA_WIDTH, 6, word width of main FIFO and VC FIFOs
- SEL_BIT, 4, bit index of `main_data` that selects the channel: 0 → VC0, 1 → VC1
- CNT_WIDTH, 8, width of the push counters
- clk  input  1  single clock, all logic on posedge
- reset_L  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- main_empty  input  1  main FIFO empty
- main_data  input  DATA_WIDTH  main FIFO read data, valid the cycle after `main_pop`
- VC0_full, VC0_almost_full  input  1  VC0 FIFO status
- VC1_full, VC1_almost_full  input  1  VC1 FIFO status
- main_pop  output  1  combinational pop request to main FIFO
- pop_delay_main  output  1  registered `main_pop`, i.e. `main_data` valid this cycle
- VC0_push, VC1_push  output  1  registered push strobes
- data_VC0, data_VC1  output  DATA_WIDTH  registered push data
- count_VC0, count_VC1  output  CNT_WIDTH  pushes issued per channel
- state  output  2  FSM state: IDLE=0, ACTIVE=1, PAUSE=2
- overflow_err  output  1  sticky; a word was dropped because its VC was full

## Operation
- pause = VC0_almost_full | VC0_full | VC1_almost_full | VC1_full. Both channels are checked because the destination of a word is unknown until it is read.
- main_pop = reset_L & ~main_empty & ~pause, combinational.
- pop_delay_main <= main_pop.
- When pop_delay_main=1, main_data[SEL_BIT] selects the destination:
  - 0: VC0_push <= 1 and data_VC0 <= main_data.
  - 1: VC1_push <= 1 and data_VC1 <= main_data.
  - The other push is 0. Both pushes are 0 when pop_delay_main=0.
- data_VCx holds its last value when not pushing.
- An in-flight word is always delivered even if pause rises, unless its destination VCx_full=1 in the routing cycle. In that case the push is suppressed, the word is dropped, and overflow_err <= 1 until reset.
- Counters: count_VCx increments when VCx_push is registered high and wraps from 2^CNT_WIDTH−1 to 0.
- FSM, registered, next state computed from current inputs:
  - IDLE → ACTIVE when ~main_empty & ~pause.
  - IDLE → PAUSE when ~main_empty & pause.
  - ACTIVE → PAUSE on pause.
  - ACTIVE → IDLE on main_empty & ~pause.
  - PAUSE → ACTIVE on ~pause & ~main_empty.
  - PAUSE → IDLE on ~pause & main_empty.
  - Otherwise the state holds.
  - The FSM is observational only; main_pop does not depend on `state`.
- VC FIFO almost_full thresholds must leave ≥2 free entries to absorb the 2 words that can be in flight.

## Timing
- Reset, asynchronous: pop_delay_main, VC0_push, VC1_push, data_VC0, data_VC1, count_VC0, count_VC1, overflow_err and state all go to 0 (IDLE) immediately. main_pop=0 while reset_L=0. In-flight words are discarded.
- Latency: main_pop high in cycle N → pop_delay_main high in N+1 → VCx_push and data high in N+2.
- Throughput: 1 word/cycle sustained while ~main_empty & ~pause.
- pause asserting in cycle N gives main_pop=0 in cycle N. Words popped in N−1 and N−2 still push.
- First pop after reset release: the first cycle with reset_L=1 & ~main_empty & ~pause.
- Simultaneous almost_full on both VCs behaves the same as on one: pause.

## Test plan
- Reset: hold reset_L=0 mid-stream with traffic → all registered outputs 0 within the same cycle, main_pop=0; after release, no stale push is issued.
- Single word: main_data=6'b000101 (bit4=0) with one pop at cycle 0 → VC0_push=1 and data_VC0=6'h05 at cycle 2, VC1_push=0, count_VC0=1, state ACTIVE→IDLE.
- Alternating stream: 6'h10, 6'h01, 6'h1F, 6'h02 popped back to back → pushes VC1, VC0, VC1, VC0 on consecutive cycles with matching data; both counts end at 2.
- Backpressure: VC1_almost_full=1 during a stream → main_pop drops the same cycle, the 2 in-flight words are still pushed, state=PAUSE; on release, popping resumes and state=ACTIVE.
- Overflow: force VC0_full=1 in the cycle an in-flight VC0 word routes → VC0_push=0, overflow_err=1 and stays 1 until reset.
- Counter wrap: 256 consecutive VC1 words → count_VC1 returns to 0 and count_VC0 stays 0.

Source files
------------

// File: rtl/logica_push_vc_if.sv
// Main-FIFO read port and VC0/VC1 FIFO write ports seen by the VC push logic.
// Handshake: main_pop pops the main FIFO when it is not empty, and the word appears on main_data one cycle later;
// VCx_push writes data_VCx into VCx in that same cycle, and VCx_almost_full/VCx_full act as ready (low = accept).
interface logica_push_vc_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  main_empty;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  main_pop;
  logic                  VC0_full;
  logic                  VC0_almost_full;
  logic                  VC1_full;
  logic                  VC1_almost_full;
  logic                  VC0_push;
  logic                  VC1_push;
  logic [DATA_WIDTH-1:0] data_VC0;
  logic [DATA_WIDTH-1:0] data_VC1;

  modport master (
    input  main_empty, main_data,
    input  VC0_full, VC0_almost_full, VC1_full, VC1_almost_full,
    output main_pop, VC0_push, VC1_push, data_VC0, data_VC1
  );

  modport slave (
    output main_empty, main_data,
    output VC0_full, VC0_almost_full, VC1_full, VC1_almost_full,
    input  main_pop, VC0_push, VC1_push, data_VC0, data_VC1
  );
endinterface

// File: rtl/logica_push_vc.sv
// Drains the main FIFO and routes each word to VC0 or VC1 by its class bit.
// Per-channel push counters, a sticky overflow flag and an observational FSM are provided for checking.
module logica_push_vc #(
  parameter int DATA_WIDTH = 6,
  parameter int SEL_BIT    = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  logica_push_vc_if.master     vc_if,
  output logic                 pop_delay_main,
  output logic [CNT_WIDTH-1:0] count_VC0,
  output logic [CNT_WIDTH-1:0] count_VC1,
  output logic [1:0]           state,
  output logic                 overflow_err
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] word;
  logic                  pause;
  logic                  push0_d;
  logic                  push1_d;
  logic                  drop_d;
  logic                  vc0_push_q;
  logic                  vc1_push_q;
  logic [DATA_WIDTH-1:0] data_vc0_q;
  logic [DATA_WIDTH-1:0] data_vc1_q;

  // Both channels gate the pop: the destination is unknown until the word is read.
  assign pause = vc_if.VC0_almost_full | vc_if.VC0_full |
                 vc_if.VC1_almost_full | vc_if.VC1_full;
  assign vc_if.main_pop = reset_L & ~vc_if.main_empty & ~pause;
  assign word           = vc_if.main_data;

  assign vc_if.VC0_push = vc0_push_q;
  assign vc_if.VC1_push = vc1_push_q;
  assign vc_if.data_VC0 = data_vc0_q;
  assign vc_if.data_VC1 = data_vc1_q;

  // An in-flight word is only lost when its own channel is completely full.
  always_comb begin
    push0_d = 1'b0;
    push1_d = 1'b0;
    drop_d  = 1'b0;
    if (pop_delay_main) begin
      if (word[SEL_BIT]) begin
        if (vc_if.VC1_full) drop_d  = 1'b1;
        else                push1_d = 1'b1;
      end else begin
        if (vc_if.VC0_full) drop_d  = 1'b1;
        else                push0_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_delay_main <= 1'b0;
      vc0_push_q     <= 1'b0;
      vc1_push_q     <= 1'b0;
      data_vc0_q     <= '0;
      data_vc1_q     <= '0;
      count_VC0      <= '0;
      count_VC1      <= '0;
      overflow_err   <= 1'b0;
    end else begin
      pop_delay_main <= vc_if.main_pop;
      vc0_push_q     <= push0_d;
      vc1_push_q     <= push1_d;
      if (push0_d) begin
        data_vc0_q <= word;
        count_VC0  <= count_VC0 + CNT_WIDTH'(1);
      end
      if (push1_d) begin
        data_vc1_q <= word;
        count_VC1  <= count_VC1 + CNT_WIDTH'(1);
      end
      if (drop_d) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ACTIVE and PAUSE leave on the same conditions; IDLE waits for data first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!vc_if.main_empty) state_d = pause ? PAUSE : ACTIVE;
      end
      ACTIVE: begin
        if (pause)                 state_d = PAUSE;
        else if (vc_if.main_empty) state_d = IDLE;
      end
      PAUSE: begin
        if (!pause) state_d = vc_if.main_empty ? IDLE : ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    state = state_q;
  end
endmodule

// File: tb/tb_logica_push_vc.sv
// Bench for logica_push_vc: truth-table vectors, directed corner sequences and
// randomized traffic, all checked against an in-flight-queue reference model.
module tb_logica_push_vc;
  localparam int DW = 6;
  localparam int SEL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          pop_delay_main;
  logic [CW-1:0] count_VC0;
  logic [CW-1:0] count_VC1;
  logic [1:0]    state;
  logic          overflow_err;

  logica_push_vc_if #(.DATA_WIDTH(DW)) vc_if ();

  logica_push_vc #(.DATA_WIDTH(DW), .SEL_BIT(SEL), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .vc_if          (vc_if),
    .pop_delay_main (pop_delay_main),
    .count_VC0      (count_VC0),
    .count_VC1      (count_VC1),
    .state          (state),
    .overflow_err   (overflow_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  typedef struct {
    logic rst_n;
    logic force_empty;
    logic af0;
    logic f0;
    logic af1;
    logic f1;
    logic exp_pop;
  } vec_t;

  // ---------------- environment + reference model state ----------------
  logic [DW-1:0] src_q[$];   // words waiting in the main FIFO
  logic [DW-1:0] exp_q[$];   // popped words not yet routed
  int            tag_q[$];   // cycle each in-flight word was popped
  logic [DW-1:0] next_data;
  logic          have_next;
  int            cyc;
  int            n_checks;
  int            n_errors;

  logic          m_pd, m_p0, m_p1, m_ovf;
  logic [DW-1:0] m_d0, m_d1;
  int            m_c0, m_c1, m_st;
  logic          prev_rst, prev_pop, prev_empty, prev_pause, prev_f0, prev_f1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // FSM rule table: IDLE waits for data; ACTIVE/PAUSE follow pause, then emptiness.
  function automatic int next_state(input int s, input logic empty, input logic pz);
    if (s == 0) return empty ? 0 : (pz ? 2 : 1);
    if (pz) return 2;
    return empty ? 0 : 1;
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic fe, input logic af0,
                              input logic f0, input logic af1, input logic f1);
    vec_t v;
    v.rst_n = rst_n; v.force_empty = fe; v.af0 = af0; v.f0 = f0;
    v.af1 = af1; v.f1 = f1; v.exp_pop = 1'b0;
    return v;
  endfunction

  // One clock cycle: apply inputs after the edge, advance the model, compare before the next edge.
  task automatic run_cycle(input vec_t v);
    logic          pz;
    logic          pop_now;
    logic          full;
    logic [DW-1:0] w;
    @(posedge clk);
    #1;
    cyc++;
    reset_L               = v.rst_n;
    vc_if.VC0_almost_full = v.af0;
    vc_if.VC0_full        = v.f0;
    vc_if.VC1_almost_full = v.af1;
    vc_if.VC1_full        = v.f1;
    vc_if.main_empty      = v.force_empty || (src_q.size() == 0);
    vc_if.main_data       = have_next ? next_data : DW'($urandom);
    have_next             = 1'b0;
    pz      = v.af0 | v.f0 | v.af1 | v.f1;
    pop_now = v.rst_n & ~vc_if.main_empty & ~pz;

    // effect of the clock edge that opened this cycle
    if (prev_rst) begin
      m_pd = prev_pop;
      m_p0 = 1'b0;
      m_p1 = 1'b0;
      if (tag_q.size() > 0 && tag_q[0] == cyc - 2) begin
        w = exp_q.pop_front();
        void'(tag_q.pop_front());
        full = w[SEL] ? prev_f1 : prev_f0;
        if (full) m_ovf = 1'b1;
        else if (w[SEL]) begin m_p1 = 1'b1; m_d1 = w; m_c1 = (m_c1 + 1) % 256; end
        else begin m_p0 = 1'b1; m_d0 = w; m_c0 = (m_c0 + 1) % 256; end
      end
      m_st = next_state(m_st, prev_empty, prev_pause);
    end
    if (!v.rst_n) begin
      m_pd = 0; m_p0 = 0; m_p1 = 0; m_ovf = 0; m_d0 = '0; m_d1 = '0;
      m_c0 = 0; m_c1 = 0; m_st = 0;
      exp_q.delete();
      tag_q.delete();
    end

    #3;
    check("main_pop", 32'(vc_if.main_pop), 32'(pop_now));
    check("pop_delay_main", 32'(pop_delay_main), 32'(m_pd));
    check("VC0_push", 32'(vc_if.VC0_push), 32'(m_p0));
    check("VC1_push", 32'(vc_if.VC1_push), 32'(m_p1));
    check("data_VC0", 32'(vc_if.data_VC0), 32'(m_d0));
    check("data_VC1", 32'(vc_if.data_VC1), 32'(m_d1));
    check("count_VC0", 32'(count_VC0), 32'(m_c0));
    check("count_VC1", 32'(count_VC1), 32'(m_c1));
    check("state", 32'(state), 32'(m_st));
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));

    if (pop_now) begin
      w = src_q.pop_front();
      exp_q.push_back(w);
      tag_q.push_back(cyc);
      next_data = w;
      have_next = 1'b1;
    end
    prev_rst   = v.rst_n;
    prev_pop   = pop_now;
    prev_empty = vc_if.main_empty;
    prev_pause = pz;
    prev_f0    = v.f0;
    prev_f1    = v.f1;
  endtask

  task automatic do_reset();
    src_q.delete();
    run_cycle(mk(0, 0, 0, 0, 0, 0));
    run_cycle(mk(0, 0, 0, 0, 0, 0));
  endtask

  vec_t          tbl[10];
  logic [DW-1:0] alt_words[4];
  vec_t          go;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; have_next = 0; next_data = '0;
    m_pd = 0; m_p0 = 0; m_p1 = 0; m_ovf = 0; m_d0 = '0; m_d1 = '0;
    m_c0 = 0; m_c1 = 0; m_st = 0;
    prev_rst = 0; prev_pop = 0; prev_empty = 1; prev_pause = 0; prev_f0 = 0; prev_f1 = 0;
    vc_if.main_empty = 1'b1; vc_if.main_data = '0;
    vc_if.VC0_full = 0; vc_if.VC0_almost_full = 0; vc_if.VC1_full = 0; vc_if.VC1_almost_full = 0;
    go = mk(1, 0, 0, 0, 0, 0);

    // ---------------- reset state ----------------
    do_reset();
    check("rst_pop", 32'(vc_if.main_pop), 0);
    check("rst_state", 32'(state), 0);

    // ---------------- table: pop gating truth table ----------------
    tbl[0] = mk(1, 0, 0, 0, 0, 0); tbl[0].exp_pop = 1;
    tbl[1] = mk(1, 1, 0, 0, 0, 0); tbl[1].exp_pop = 0;
    tbl[2] = mk(1, 0, 1, 0, 0, 0); tbl[2].exp_pop = 0;
    tbl[3] = mk(1, 0, 0, 1, 0, 0); tbl[3].exp_pop = 0;
    tbl[4] = mk(1, 0, 0, 0, 1, 0); tbl[4].exp_pop = 0;
    tbl[5] = mk(1, 0, 0, 0, 0, 1); tbl[5].exp_pop = 0;
    tbl[6] = mk(1, 0, 1, 0, 1, 0); tbl[6].exp_pop = 0;
    tbl[7] = mk(0, 0, 0, 0, 0, 0); tbl[7].exp_pop = 0;
    tbl[8] = mk(1, 0, 0, 0, 0, 0); tbl[8].exp_pop = 1;
    tbl[9] = mk(1, 0, 0, 0, 0, 0); tbl[9].exp_pop = 1;
    for (int i = 0; i < 20; i++) src_q.push_back(DW'($urandom));
    for (int i = 0; i < 10; i++) begin
      run_cycle(tbl[i]);
      check("tbl_pop", 32'(vc_if.main_pop), 32'(tbl[i].exp_pop));
    end

    // ---------------- single word to VC0 ----------------
    do_reset();
    src_q.push_back(6'h05);
    run_cycle(go);
    check("sw_pop", 32'(vc_if.main_pop), 1);
    run_cycle(go);
    check("sw_pd", 32'(pop_delay_main), 1);
    check("sw_active", 32'(state), 1);
    run_cycle(go);
    check("sw_push0", 32'(vc_if.VC0_push), 1);
    check("sw_push1", 32'(vc_if.VC1_push), 0);
    check("sw_data0", 32'(vc_if.data_VC0), 32'h05);
    check("sw_cnt0", 32'(count_VC0), 1);
    check("sw_idle", 32'(state), 0);

    // ---------------- alternating stream ----------------
    do_reset();
    alt_words[0] = 6'h10; alt_words[1] = 6'h01; alt_words[2] = 6'h1F; alt_words[3] = 6'h02;
    for (int i = 0; i < 4; i++) src_q.push_back(alt_words[i]);
    for (int i = 0; i < 6; i++) begin
      run_cycle(go);
      if (i >= 2) begin
        check("alt_push1", 32'(vc_if.VC1_push), 32'(alt_words[i-2][SEL]));
        check("alt_push0", 32'(vc_if.VC0_push), 32'(!alt_words[i-2][SEL]));
        if (alt_words[i-2][SEL]) check("alt_data1", 32'(vc_if.data_VC1), 32'(alt_words[i-2]));
        else                     check("alt_data0", 32'(vc_if.data_VC0), 32'(alt_words[i-2]));
      end
    end
    check("alt_cnt0", 32'(count_VC0), 2);
    check("alt_cnt1", 32'(count_VC1), 2);

    // ---------------- backpressure from VC1 almost full ----------------
    do_reset();
    for (int i = 1; i <= 6; i++) src_q.push_back(DW'(i));
    run_cycle(go);
    run_cycle(go);
    run_cycle(mk(1, 0, 0, 0, 1, 0));
    check("bp_pop_drop", 32'(vc_if.main_pop), 0);
    check("bp_inflight_a", 32'(vc_if.VC0_push), 1);
    run_cycle(mk(1, 0, 0, 0, 1, 0));
    check("bp_inflight_b", 32'(vc_if.VC0_push), 1);
    check("bp_pause", 32'(state), 2);
    run_cycle(mk(1, 0, 0, 0, 1, 0));
    check("bp_no_push", 32'(vc_if.VC0_push), 0);
    run_cycle(go);
    check("bp_resume", 32'(vc_if.main_pop), 1);
    run_cycle(go);
    check("bp_active", 32'(state), 1);
    for (int i = 0; i < 6; i++) run_cycle(go);

    // ---------------- overflow on VC0 full ----------------
    do_reset();
    src_q.push_back(6'h05);
    run_cycle(go);
    run_cycle(mk(1, 0, 0, 1, 0, 0));
    run_cycle(go);
    check("ovf_no_push", 32'(vc_if.VC0_push), 0);
    check("ovf_set", 32'(overflow_err), 1);
    for (int i = 0; i < 3; i++) run_cycle(go);
    check("ovf_sticky", 32'(overflow_err), 1);
    run_cycle(mk(0, 0, 0, 0, 0, 0));
    check("ovf_cleared", 32'(overflow_err), 0);

    // ---------------- counter wrap on VC1 ----------------
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [DW-1:0] w;
      w = DW'($urandom);
      w[SEL] = 1'b1;
      src_q.push_back(w);
    end
    for (int i = 0; i < 262; i++) begin
      run_cycle(go);
      if (i == 256) check("wrap_max", 32'(count_VC1), 255);
      if (i == 257) check("wrap_zero", 32'(count_VC1), 0);
    end
    check("wrap_cnt1", 32'(count_VC1), 0);
    check("wrap_cnt0", 32'(count_VC0), 0);

    // ---------------- reset mid-stream ----------------
    do_reset();
    for (int i = 0; i < 10; i++) src_q.push_back(DW'($urandom));
    for (int i = 0; i < 3; i++) run_cycle(go);
    run_cycle(mk(0, 0, 0, 0, 0, 0));
    check("mrst_pop", 32'(vc_if.main_pop), 0);
    check("mrst_pd", 32'(pop_delay_main), 0);
    check("mrst_push", 32'({vc_if.VC0_push, vc_if.VC1_push}), 0);
    check("mrst_cnt", 32'({count_VC0, count_VC1}), 0);
    run_cycle(mk(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      run_cycle(mk(1, 1, 0, 0, 0, 0));
      check("mrst_stale", 32'({vc_if.VC0_push, vc_if.VC1_push}), 0);
    end

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 1500; i++) begin
      vec_t v;
      v = mk($urandom_range(0, 199) != 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
      if (src_q.size() < 4)
        for (int k = 0; k < 4; k++) src_q.push_back(DW'($urandom));
      run_cycle(v);
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
